// File: rtl/decode_scoreboard_pkg.sv
// Shared types and constants for the DECODE-stage hazard scoreboard.
package decode_scoreboard_pkg;

  localparam int unsigned PC_ADDR  = 15;
  localparam int unsigned SB_AGE_W = 4;

  typedef logic stall_pipeline_sig_t;

  // Age is stored with a fixed width, so LOAD_LATENCY must stay below 2**SB_AGE_W.
  typedef struct packed {
    logic                busy;
    logic                is_load;
    logic [SB_AGE_W-1:0] age;
  } scoreboard_entry_t;

  function automatic logic [SB_AGE_W-1:0] producer_latency(
    input logic        is_load,
    input int unsigned load_lat,
    input int unsigned alu_lat
  );
    return is_load ? SB_AGE_W'(load_lat) : SB_AGE_W'(alu_lat);
  endfunction

endpackage

// File: rtl/decode_scoreboard_if.sv
// DECODE-side bundle for the scoreboard: source/destination info in, stall and status out.
interface decode_scoreboard_if #(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned NUM_SRC    = 3,
  parameter int unsigned CNT_WIDTH  = 16
);
  logic                          issue_valid_i;
  logic [NUM_SRC-1:0]            src_valid_i;
  logic [NUM_SRC*ADDR_WIDTH-1:0] src_addr_i;
  logic                          dest_we_i;
  logic [ADDR_WIDTH-1:0]         dest_addr_i;
  logic                          dest_is_load_i;
  logic                          flush_i;
  logic                          stall_o;
  logic [2**ADDR_WIDTH-1:0]      busy_vec_o;
  logic [CNT_WIDTH-1:0]          stall_count_o;

  modport master (
    output issue_valid_i, src_valid_i, src_addr_i, dest_we_i, dest_addr_i,
           dest_is_load_i, flush_i,
    input  stall_o, busy_vec_o, stall_count_o
  );

  modport slave (
    input  issue_valid_i, src_valid_i, src_addr_i, dest_we_i, dest_addr_i,
           dest_is_load_i, flush_i,
    output stall_o, busy_vec_o, stall_count_o
  );
endinterface

// File: rtl/decode_scoreboard_entry.sv
// One scoreboard slot: tracks a pending producer of a single register and its age.
module scoreboard_entry
  import decode_scoreboard_pkg::*;
#(
  parameter int unsigned LOAD_LATENCY = 2,
  parameter int unsigned ALU_LATENCY  = 1,
  parameter int unsigned FLUSH_WINDOW = 2
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic issue_i,
  input  logic is_load_i,
  input  logic flush_i,
  output logic busy_o,
  output logic ready_o
);

  localparam logic [SB_AGE_W-1:0] LOAD_LAT_C  = SB_AGE_W'(LOAD_LATENCY);
  localparam logic [SB_AGE_W-1:0] FLUSH_WIN_C = SB_AGE_W'(FLUSH_WINDOW);

  scoreboard_entry_t   ent_q, ent_d;
  logic [SB_AGE_W-1:0] lat;
  logic                aged_out;

  always_comb begin
    ent_d    = ent_q;
    lat      = producer_latency(ent_q.is_load, LOAD_LATENCY, ALU_LATENCY);
    aged_out = (ent_q.age >= lat);
    if (ent_q.busy && flush_i && (ent_q.age < FLUSH_WIN_C)) begin
      ent_d = '0;
    end else if (issue_i) begin
      // A new producer replaces whatever was here, even one retiring this edge.
      ent_d.busy    = 1'b1;
      ent_d.is_load = is_load_i;
      ent_d.age     = SB_AGE_W'(1);
    end else if (ent_q.busy && aged_out) begin
      ent_d = '0;
    end else if (ent_q.busy && (ent_q.age < LOAD_LAT_C)) begin
      ent_d.age = ent_q.age + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) ent_q <= '0;
    else          ent_q <= ent_d;
  end

  assign busy_o  = ent_q.busy;
  assign ready_o = !ent_q.busy || aged_out;

endmodule

// File: rtl/decode_scoreboard.sv
// Multi-source RAW hazard detection for DECODE with per-register producer latency tracking.
module decode_scoreboard
  import decode_scoreboard_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 4,
  parameter int unsigned NUM_SRC        = 3,
  parameter int unsigned LOAD_LATENCY   = 2,
  parameter int unsigned ALU_LATENCY    = 1,
  parameter int unsigned FLUSH_WINDOW   = 2,
  parameter int unsigned UNTRACKED_ADDR = PC_ADDR,
  parameter int unsigned CNT_WIDTH      = 16
) (
  input logic                clk_i,
  input logic                reset_i,
  decode_scoreboard_if.slave sb_if
);

  localparam int unsigned NUM_REGS = 2**ADDR_WIDTH;

  logic [NUM_REGS-1:0]  ready_vec;
  logic [NUM_REGS-1:0]  busy_vec;
  logic [NUM_REGS-1:0]  issue_vec;
  logic                 hazard;
  stall_pipeline_sig_t  stall;
  logic                 issue_fire;
  logic [CNT_WIDTH-1:0] stall_count_q, stall_count_d;

  always_comb begin
    hazard = 1'b0;
    for (int unsigned s = 0; s < NUM_SRC; s++) begin
      if (sb_if.src_valid_i[s] &&
          !ready_vec[sb_if.src_addr_i[s*ADDR_WIDTH +: ADDR_WIDTH]]) begin
        hazard = 1'b1;
      end
    end
    stall = sb_if.issue_valid_i && hazard;
  end

  assign issue_fire = sb_if.issue_valid_i && !stall && sb_if.dest_we_i && !sb_if.flush_i &&
                      (sb_if.dest_addr_i != ADDR_WIDTH'(UNTRACKED_ADDR));

  for (genvar r = 0; r < NUM_REGS; r++) begin : g_entry
    assign issue_vec[r] = issue_fire && (sb_if.dest_addr_i == ADDR_WIDTH'(r));

    scoreboard_entry #(
      .LOAD_LATENCY (LOAD_LATENCY),
      .ALU_LATENCY  (ALU_LATENCY),
      .FLUSH_WINDOW (FLUSH_WINDOW)
    ) u_entry (
      .clk_i     (clk_i),
      .reset_i   (reset_i),
      .issue_i   (issue_vec[r]),
      .is_load_i (sb_if.dest_is_load_i),
      .flush_i   (sb_if.flush_i),
      .busy_o    (busy_vec[r]),
      .ready_o   (ready_vec[r])
    );
  end

  always_comb begin
    stall_count_d = stall_count_q;
    if (stall && (stall_count_q != '1)) stall_count_d = stall_count_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) stall_count_q <= '0;
    else          stall_count_q <= stall_count_d;
  end

  assign sb_if.stall_o       = stall;
  assign sb_if.busy_vec_o    = busy_vec;
  assign sb_if.stall_count_o = stall_count_q;

endmodule

// File: tb/tb_decode_scoreboard.sv
// Scoreboard-style bench: stimulus queues expected outputs, a monitor compares them at negedge.
module tb_decode_scoreboard;

  logic clk;
  logic reset_n;

  decode_scoreboard_if #(.ADDR_WIDTH(4), .NUM_SRC(3), .CNT_WIDTH(16)) m_if ();
  decode_scoreboard_if #(.ADDR_WIDTH(4), .NUM_SRC(3), .CNT_WIDTH(4))  s_if ();

  decode_scoreboard #(
    .ADDR_WIDTH(4), .NUM_SRC(3), .LOAD_LATENCY(2), .ALU_LATENCY(1),
    .FLUSH_WINDOW(2), .UNTRACKED_ADDR(15), .CNT_WIDTH(16)
  ) u_dut (
    .clk_i   (clk),
    .reset_i (reset_n),
    .sb_if   (m_if)
  );

  decode_scoreboard #(
    .ADDR_WIDTH(4), .NUM_SRC(3), .LOAD_LATENCY(2), .ALU_LATENCY(1),
    .FLUSH_WINDOW(2), .UNTRACKED_ADDR(15), .CNT_WIDTH(4)
  ) u_dut_sat (
    .clk_i   (clk),
    .reset_i (reset_n),
    .sb_if   (s_if)
  );

  typedef struct {
    string       name;
    bit          sel;
    bit          stall;
    logic [15:0] busy;
    logic [15:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  event sample_now;
  int   checks   = 0;
  int   failures = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  // Monitor
  initial begin : monitor
    exp_t        e;
    logic        act_st;
    logic [15:0] act_bz;
    logic [15:0] act_cn;
    forever begin
      @(negedge clk or sample_now);
      while (exp_q.size() > 0) begin
        e      = exp_q.pop_front();
        act_st = e.sel ? s_if.stall_o    : m_if.stall_o;
        act_bz = e.sel ? s_if.busy_vec_o : m_if.busy_vec_o;
        act_cn = e.sel ? 16'(s_if.stall_count_o) : m_if.stall_count_o;
        checks++;
        if (act_st !== e.stall) begin
          failures++;
          $display("FAIL %s.stall got=%0b exp=%0b", e.name, act_st, e.stall);
        end
        checks++;
        if (act_bz !== e.busy) begin
          failures++;
          $display("FAIL %s.busy got=%04h exp=%04h", e.name, act_bz, e.busy);
        end
        checks++;
        if (act_cn !== e.cnt) begin
          failures++;
          $display("FAIL %s.count got=%0d exp=%0d", e.name, act_cn, e.cnt);
        end
      end
    end
  end

  task automatic expect_out(input string nm, input bit sel, input bit st,
                            input logic [15:0] bz, input logic [15:0] cn);
    exp_t e;
    e.name  = nm;
    e.sel   = sel;
    e.stall = st;
    e.busy  = bz;
    e.cnt   = cn;
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_main(input bit iv, input bit [2:0] sv,
                          input logic [3:0] a0, input logic [3:0] a1, input logic [3:0] a2,
                          input bit we, input logic [3:0] d, input bit ld, input bit fl);
    m_if.issue_valid_i  = iv;
    m_if.src_valid_i    = sv;
    m_if.src_addr_i     = {a2, a1, a0};
    m_if.dest_we_i      = we;
    m_if.dest_addr_i    = d;
    m_if.dest_is_load_i = ld;
    m_if.flush_i        = fl;
  endtask

  task automatic set_sat(input bit iv, input bit [2:0] sv, input logic [3:0] a0,
                         input bit we, input logic [3:0] d, input bit ld);
    s_if.issue_valid_i  = iv;
    s_if.src_valid_i    = sv;
    s_if.src_addr_i     = {4'd0, 4'd0, a0};
    s_if.dest_we_i      = we;
    s_if.dest_addr_i    = d;
    s_if.dest_is_load_i = ld;
    s_if.flush_i        = 1'b0;
  endtask

  task automatic idle_main();
    set_main(0, 3'b000, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin : stimulus
    reset_n = 1'b0;
    idle_main();
    set_sat(0, 3'b000, 0, 0, 0, 0);
    #1;
    expect_out("reset", 0, 0, 16'h0000, 0);
    expect_out("reset_sat", 1, 0, 16'h0000, 0);
    #10 reset_n = 1'b1;

    // load r3 then dependent reader: one stall cycle
    step(); set_main(1, 3'b001, 0, 0, 0, 1, 3, 1, 0); m_if.src_valid_i = 3'b000;
    expect_out("ld_issue", 0, 0, 16'h0000, 0);
    step(); set_main(1, 3'b001, 3, 0, 0, 0, 0, 0, 0);
    expect_out("ld_dep_stall", 0, 1, 16'h0008, 0);
    step(); expect_out("ld_dep_go", 0, 0, 16'h0008, 1);
    step(); idle_main(); expect_out("ld_retired", 0, 0, 16'h0000, 1);

    // ALU r4 then reader on src1: no stall
    step(); set_main(1, 3'b000, 0, 0, 0, 1, 4, 0, 0);
    expect_out("alu_issue", 0, 0, 16'h0000, 1);
    step(); set_main(1, 3'b010, 0, 4, 0, 0, 0, 0, 0);
    expect_out("alu_dep", 0, 0, 16'h0010, 1);
    step(); idle_main(); expect_out("alu_retired", 0, 0, 16'h0000, 1);

    // WAW: load r5 then ALU r5, reader on src2
    step(); set_main(1, 3'b000, 0, 0, 0, 1, 5, 1, 0);
    expect_out("waw_ld", 0, 0, 16'h0000, 1);
    step(); set_main(1, 3'b000, 0, 0, 0, 1, 5, 0, 0);
    expect_out("waw_alu", 0, 0, 16'h0020, 1);
    step(); set_main(1, 3'b100, 0, 0, 5, 0, 0, 0, 0);
    expect_out("waw_reader", 0, 0, 16'h0020, 1);
    step(); idle_main(); expect_out("waw_retired", 0, 0, 16'h0000, 1);

    // WAW: ALU r8 then load r8 retiring the same edge; younger load must stall its reader
    step(); set_main(1, 3'b000, 0, 0, 0, 1, 8, 0, 0);
    expect_out("waw2_alu", 0, 0, 16'h0000, 1);
    step(); set_main(1, 3'b000, 0, 0, 0, 1, 8, 1, 0);
    expect_out("waw2_ld", 0, 0, 16'h0100, 1);
    step(); set_main(1, 3'b001, 8, 0, 0, 0, 0, 0, 0);
    expect_out("waw2_stall", 0, 1, 16'h0100, 1);
    step(); expect_out("waw2_go", 0, 0, 16'h0100, 2);
    step(); idle_main(); expect_out("waw2_retired", 0, 0, 16'h0000, 2);

    // flush squashes young load r6 and blocks issue of r7
    step(); set_main(1, 3'b000, 0, 0, 0, 1, 6, 1, 0);
    expect_out("fl_ld", 0, 0, 16'h0000, 2);
    step(); set_main(1, 3'b000, 0, 0, 0, 1, 7, 1, 1);
    expect_out("fl_edge", 0, 0, 16'h0040, 2);
    step(); set_main(1, 3'b001, 6, 0, 0, 0, 0, 0, 0);
    expect_out("fl_reader", 0, 0, 16'h0000, 2);
    step(); idle_main(); expect_out("fl_idle", 0, 0, 16'h0000, 2);

    // PC register is never tracked
    step(); set_main(1, 3'b000, 0, 0, 0, 1, 15, 1, 0);
    expect_out("pc_ld", 0, 0, 16'h0000, 2);
    step(); set_main(1, 3'b001, 15, 0, 0, 0, 0, 0, 0);
    expect_out("pc_reader", 0, 0, 16'h0000, 2);
    step(); idle_main(); expect_out("pc_idle", 0, 0, 16'h0000, 2);

    // asynchronous reset between edges
    step(); set_main(1, 3'b000, 0, 0, 0, 1, 2, 1, 0);
    expect_out("rst_ld", 0, 0, 16'h0000, 2);
    step(); set_main(1, 3'b001, 2, 0, 0, 0, 0, 0, 0);
    expect_out("rst_busy", 0, 1, 16'h0004, 2);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1 expect_out("rst_async", 0, 0, 16'h0000, 0);
    -> sample_now;
    step(); idle_main(); reset_n = 1'b1;
    expect_out("rst_hold", 0, 0, 16'h0000, 0);

    // saturation on the 4-bit counter: load r1 reading r1 stalls every other cycle
    step(); set_sat(1, 3'b001, 1, 1, 1, 1);
    for (int k = 1; k <= 40; k++) begin
      step();
      if (k == 14) expect_out("sat_k14", 1, 0, 16'h0002, 7);
      if (k == 31) expect_out("sat_k31", 1, 1, 16'h0002, 15);
      if (k == 33) expect_out("sat_k33", 1, 1, 16'h0002, 15);
      if (k == 40) expect_out("sat_k40", 1, 0, 16'h0002, 15);
    end
    step(); set_sat(0, 3'b000, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
